// File: rtl/packet_pkg.sv
// Shared definitions for the packet deframer: parser state encoding,
// default geometry and the helper that builds the header length-field mask.
package packet_pkg;

  // Parser state: collecting header words or forwarding payload words.
  typedef enum logic [0:0] {
    HEADER  = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  localparam int unsigned PKT_WORD_SIZE    = 8;
  localparam int unsigned PKT_HEADER_WORDS = 1;
  localparam int unsigned PKT_LENGTH_BITS  = 4;
  localparam int unsigned PKT_MAX_HDR_BITS = 64;

  // Ones in the low len_bits positions: selects the length field of a header.
  function automatic logic [PKT_MAX_HDR_BITS-1:0] length_mask(input int unsigned len_bits);
    logic [PKT_MAX_HDR_BITS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PKT_MAX_HDR_BITS; i++) begin
      m[i] = (i < len_bits);
    end
    return m;
  endfunction

endpackage

// File: rtl/packet_deframer.sv
// packet_deframer: strips a HEADER_WORDS-word header (tag | length) from a
// popped word stream and presents payload words in a registered output stage
// with start/end markers and the decoded length.
// Optional feature: define PACKET_DEFRAMER_HEADER_CHECK_EN to compare each
// header word against the expected tag (length bits masked), drop mismatching
// words, and count them in a saturating err_count. Without it every header is
// accepted and err_count is tied to zero.
module packet_deframer
  import packet_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = PKT_WORD_SIZE,
  parameter int unsigned HEADER_WORDS = PKT_HEADER_WORDS,
  parameter int unsigned LENGTH_BITS  = PKT_LENGTH_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_nempty,
  output logic                           in_pop,
  input  logic [WORD_SIZE-1:0]           in_data,
  input  logic [HEADER_WORDS*WORD_SIZE-1:0] header,
  output logic                           out_nempty,
  input  logic                           out_pop,
  output logic [WORD_SIZE-1:0]           out_data,
  output logic                           out_start,
  output logic                           out_end,
  output logic [LENGTH_BITS-1:0]         out_length,
  output logic [15:0]                    err_count
);

  localparam int unsigned HDR_W = HEADER_WORDS * WORD_SIZE;
  localparam int unsigned CNT_W = (HEADER_WORDS > 1) ? $clog2(HEADER_WORDS) : 1;
  localparam logic [HDR_W-1:0] LEN_MASK = HDR_W'(length_mask(LENGTH_BITS));
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HEADER_WORDS - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [HDR_W-1:0]       hdr_shift_q, hdr_shift_d;
  logic [LENGTH_BITS-1:0] len_q, len_d;
  logic [LENGTH_BITS-1:0] rem_q, rem_d;
  logic                   out_nempty_q, out_nempty_d;
  logic [WORD_SIZE-1:0]   out_data_q, out_data_d;
  logic                   out_start_q, out_start_d;
  logic                   out_end_q, out_end_d;
  logic [LENGTH_BITS-1:0] out_length_q, out_length_d;

  logic [HDR_W-1:0]       assembled_s;
  logic [LENGTH_BITS-1:0] hdr_len_s;
  logic                   hdr_ok_s;

  // Header is shifted in first-word-most-significant; the current word joins the low end.
  assign assembled_s = HDR_W'({hdr_shift_q, in_data});
  assign hdr_len_s   = LENGTH_BITS'(assembled_s & LEN_MASK);

`ifdef PACKET_DEFRAMER_HEADER_CHECK_EN
  logic [15:0]          err_q, err_d;
  int unsigned          shamt_s;
  logic [WORD_SIZE-1:0] exp_word_s;
  logic [WORD_SIZE-1:0] mask_word_s;

  // Select the expected tag word for the current header position, length bits masked out.
  always_comb begin
    shamt_s     = (HEADER_WORDS - 32'd1 - 32'(hdr_cnt_q)) * WORD_SIZE;
    exp_word_s  = WORD_SIZE'((header & ~LEN_MASK) >> shamt_s);
    mask_word_s = WORD_SIZE'(LEN_MASK >> shamt_s);
    hdr_ok_s    = ((in_data & ~mask_word_s) == exp_word_s);
  end

  // Saturating count of header words rejected while hunting for a valid tag.
  always_comb begin
    if ((state_q == HEADER) && in_pop && !hdr_ok_s) begin
      if (err_q == 16'hFFFF) begin
        err_d = err_q;
      end else begin
        err_d = err_q + 16'd1;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 16'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`else
  logic unused_hdr_s;
  assign unused_hdr_s = ^header;
  assign hdr_ok_s     = 1'b1;
  assign err_count    = 16'd0;
`endif

  // Header words are always accepted; payload words only when the output stage frees up.
  assign in_pop = in_nempty && ((state_q == HEADER) || !out_nempty_q || out_pop);

  // Next-state, header parsing, and output-stage load/unload.
  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    hdr_shift_d  = hdr_shift_q;
    len_d        = len_q;
    rem_d        = rem_q;
    out_data_d   = out_data_q;
    out_start_d  = out_start_q;
    out_end_d    = out_end_q;
    out_length_d = out_length_q;
    if (out_nempty_q && out_pop) begin
      out_nempty_d = 1'b0;
    end else begin
      out_nempty_d = out_nempty_q;
    end

    case (state_q)
      HEADER: begin
        if (in_pop) begin
          if (!hdr_ok_s) begin
            hdr_cnt_d   = '0;
            hdr_shift_d = '0;
          end else if (hdr_cnt_q == LAST_HDR) begin
            hdr_cnt_d   = '0;
            hdr_shift_d = '0;
            len_d       = hdr_len_s;
            rem_d       = hdr_len_s;
            if (hdr_len_s != '0) begin
              state_d = PAYLOAD;
            end else begin
              state_d = HEADER;
            end
          end else begin
            hdr_shift_d = assembled_s;
            hdr_cnt_d   = hdr_cnt_q + CNT_W'(1'b1);
          end
        end else begin
          state_d = HEADER;
        end
      end
      PAYLOAD: begin
        if (in_pop) begin
          out_nempty_d = 1'b1;
          out_data_d   = in_data;
          out_start_d  = (rem_q == len_q);
          out_end_d    = (rem_q == LENGTH_BITS'(1'b1));
          out_length_d = len_q;
          rem_d        = rem_q - LENGTH_BITS'(1'b1);
          if (rem_q == LENGTH_BITS'(1'b1)) begin
            state_d   = HEADER;
            hdr_cnt_d = '0;
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          state_d = PAYLOAD;
        end
      end
      default: begin
        state_d   = HEADER;
        hdr_cnt_d = '0;
      end
    endcase
  end

  // State, counters and the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HEADER;
      hdr_cnt_q    <= '0;
      hdr_shift_q  <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      out_nempty_q <= 1'b0;
      out_data_q   <= '0;
      out_start_q  <= 1'b0;
      out_end_q    <= 1'b0;
      out_length_q <= '0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      hdr_shift_q  <= hdr_shift_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      out_nempty_q <= out_nempty_d;
      out_data_q   <= out_data_d;
      out_start_q  <= out_start_d;
      out_end_q    <= out_end_d;
      out_length_q <= out_length_d;
    end
  end

  assign out_nempty = out_nempty_q;
  assign out_data   = out_data_q;
  assign out_start  = out_start_q;
  assign out_end    = out_end_q;
  assign out_length = out_length_q;

endmodule
